// File: rtl/time_pkg.sv
// Shared types and limits for the elapsed-time counter.
package time_pkg;

   localparam int unsigned CLK_HZ_DEFAULT = 12_000_000;
   localparam int unsigned MAX_MIN_LIMIT  = 99;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      bcd_t min_t;
      bcd_t min_o;
      bcd_t sec_t;
      bcd_t sec_o;
   } time_bcd_t;

   // Binary 0..99 to two BCD digits {tens, ones}.
   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      logic [6:0] tens;
      tens = v / 7'd10;
      return {4'(tens), 4'(v - tens * 7'd10)};
   endfunction

endpackage

// File: rtl/elapsed_time_counter_if.sv
// Command, configuration and display bundle of the elapsed-time counter.
interface elapsed_time_counter_if #(
   parameter int unsigned SPD_W = 3
);
   import time_pkg::*;

   logic             i_start;
   logic             i_pause;
   logic             i_stop;
   logic             i_down;
   logic [6:0]       i_preset_min;
   logic [5:0]       i_preset_sec;
   logic             i_fast;
   logic             i_slow;
   logic [SPD_W-1:0] i_speed;
   bcd_t             o_min_t;
   bcd_t             o_min_o;
   bcd_t             o_sec_t;
   bcd_t             o_sec_o;
   logic [12:0]      o_total_sec;
   logic             o_tick;
   logic             o_wrap;
   logic             o_done;
   logic             o_running;

   modport master (
      output i_start, i_pause, i_stop, i_down, i_preset_min, i_preset_sec,
             i_fast, i_slow, i_speed,
      input  o_min_t, o_min_o, o_sec_t, o_sec_o, o_total_sec,
             o_tick, o_wrap, o_done, o_running
   );

   modport slave (
      input  i_start, i_pause, i_stop, i_down, i_preset_min, i_preset_sec,
             i_fast, i_slow, i_speed,
      output o_min_t, o_min_o, o_sec_t, o_sec_o, o_total_sec,
             o_tick, o_wrap, o_done, o_running
   );

endinterface

// File: rtl/time_bcd_counter.sv
// mm:ss BCD up/down counter with load, enable and wrap/zero look-ahead flags.
module time_bcd_counter
   import time_pkg::*;
#(
   parameter int unsigned MAX_MIN = MAX_MIN_LIMIT
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  time_bcd_t load_val,
   input  logic      en,
   input  logic      down,
   output time_bcd_t value,
   output logic      wrap_c,
   output logic      zero_c
);

   localparam bcd_t MAX_T = 4'(MAX_MIN / 10);
   localparam bcd_t MAX_O = 4'(MAX_MIN % 10);

   logic      at_max;
   logic      at_one;
   time_bcd_t nxt;

   // Flags describe what the advance enabled this cycle is about to do.
   always_comb begin
      at_max = (value.min_t == MAX_T) && (value.min_o == MAX_O) &&
               (value.sec_t == 4'd5) && (value.sec_o == 4'd9);
      at_one = (value.min_t == 4'd0) && (value.min_o == 4'd0) &&
               (value.sec_t == 4'd0) && (value.sec_o == 4'd1);
      wrap_c = en && !down && at_max;
      zero_c = en && down && at_one;
   end

   // Next display value for one second forward or backward.
   always_comb begin
      nxt = value;
      if (down) begin
         if (value.sec_o != 4'd0) begin
            nxt.sec_o = value.sec_o - 4'd1;
         end else begin
            nxt.sec_o = 4'd9;
            if (value.sec_t != 4'd0) begin
               nxt.sec_t = value.sec_t - 4'd1;
            end else begin
               nxt.sec_t = 4'd5;
               if (value.min_o != 4'd0) begin
                  nxt.min_o = value.min_o - 4'd1;
               end else begin
                  nxt.min_o = 4'd9;
                  if (value.min_t != 4'd0) nxt.min_t = value.min_t - 4'd1;
               end
            end
         end
      end else if (at_max) begin
         nxt = '0;
      end else begin
         if (value.sec_o != 4'd9) begin
            nxt.sec_o = value.sec_o + 4'd1;
         end else begin
            nxt.sec_o = 4'd0;
            if (value.sec_t != 4'd5) begin
               nxt.sec_t = value.sec_t + 4'd1;
            end else begin
               nxt.sec_t = 4'd0;
               if (value.min_o != 4'd9) begin
                  nxt.min_o = value.min_o + 4'd1;
               end else begin
                  nxt.min_o = 4'd0;
                  nxt.min_t = value.min_t + 4'd1;
               end
            end
         end
      end
   end

   // Display register: load wins over advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (en) begin
         value <= nxt;
      end
   end

endmodule

// File: rtl/elapsed_time_counter.sv
// Elapsed/countdown mm:ss timer with phase-accumulator rate control.
module elapsed_time_counter
   import time_pkg::*;
#(
   parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
   parameter int unsigned SPD_W   = 3,
   parameter int unsigned MAX_MIN = MAX_MIN_LIMIT
) (
   input  logic                 clk,
   input  logic                 rst,
   elapsed_time_counter_if.slave bus
);

   localparam int unsigned ACC_W = $clog2(CLK_HZ << SPD_W) + 1;
   localparam int unsigned TOT_W = 13;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic             down_mode;
   logic [TOT_W-1:0] total;
   logic             tick;
   logic             wrap;
   logic             done;
   logic             running;

   logic             cmd_stop;
   logic             cmd_pause;
   logic             cmd_start;
   logic [6:0]       min_cl;
   logic [5:0]       sec_cl;
   logic [TOT_W-1:0] preset_total;
   logic             preset_zero;
   time_bcd_t        preset_bcd;
   logic [ACC_W-1:0] step;
   logic [ACC_W-1:0] thresh;
   logic [ACC_W-1:0] sum;
   logic             adv;
   logic             ld;
   time_bcd_t        ld_val;
   time_bcd_t        disp;
   logic             wrap_c;
   logic             zero_c;

   // Command priority: stop over pause over start.
   always_comb begin
      cmd_stop  = bus.i_stop;
      cmd_pause = !bus.i_stop && bus.i_pause;
      cmd_start = !bus.i_stop && !bus.i_pause && bus.i_start;
   end

   // Clamp the countdown preset and derive its BCD and binary forms.
   always_comb begin
      min_cl       = (bus.i_preset_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : bus.i_preset_min;
      sec_cl       = (bus.i_preset_sec > 6'd59) ? 6'd59 : bus.i_preset_sec;
      preset_total = TOT_W'(min_cl) * TOT_W'(60) + TOT_W'(sec_cl);
      preset_zero  = (min_cl == 7'd0) && (sec_cl == 6'd0);
      {preset_bcd.min_t, preset_bcd.min_o} = bin2bcd(min_cl);
      {preset_bcd.sec_t, preset_bcd.sec_o} = bin2bcd(7'(sec_cl));
   end

   // Rate select: fast raises the step, slow raises the threshold.
   always_comb begin
      step   = ACC_W'(1);
      thresh = ACC_W'(CLK_HZ);
      if (bus.i_fast) begin
         step = ACC_W'(bus.i_speed) + ACC_W'(1);
      end else if (bus.i_slow) begin
         thresh = ACC_W'(CLK_HZ) * (ACC_W'(bus.i_speed) + ACC_W'(1));
      end
      sum = acc + step;
      adv = (state == ST_COUNT) && !cmd_stop && !cmd_pause && (sum >= thresh);
   end

   // Display load on start (preset or zero) and on stop (zero).
   always_comb begin
      ld     = 1'b0;
      ld_val = '0;
      if (cmd_stop && (state != ST_IDLE)) begin
         ld = 1'b1;
      end else if (cmd_start && ((state == ST_IDLE) || (state == ST_DONE))) begin
         ld = 1'b1;
         if (bus.i_down) ld_val = preset_bcd;
      end
   end

   time_bcd_counter #(
      .MAX_MIN (MAX_MIN)
   ) u_bcd (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .en       (adv),
      .down     (down_mode),
      .value    (disp),
      .wrap_c   (wrap_c),
      .zero_c   (zero_c)
   );

   // Control FSM, accumulator, binary seconds and event pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         acc       <= '0;
         down_mode <= 1'b0;
         total     <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         done      <= 1'b0;
         running   <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         done <= 1'b0;
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (cmd_stop) begin
                  state <= ST_IDLE;
                  total <= '0;
               end else if (cmd_start) begin
                  acc       <= '0;
                  down_mode <= bus.i_down;
                  if (bus.i_down && preset_zero) begin
                     total <= '0;
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     total   <= bus.i_down ? preset_total : '0;
                     state   <= ST_COUNT;
                     running <= 1'b1;
                  end
               end
            end
            ST_COUNT: begin
               if (cmd_stop) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                  acc     <= '0;
                  total   <= '0;
               end else if (cmd_pause) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end else begin
                  acc <= adv ? (sum - thresh) : sum;
                  if (adv) begin
                     tick <= 1'b1;
                     if (wrap_c) begin
                        total <= '0;
                        wrap  <= 1'b1;
                     end else if (down_mode) begin
                        total <= total - TOT_W'(1);
                     end else begin
                        total <= total + TOT_W'(1);
                     end
                     if (zero_c) begin
                        done    <= 1'b1;
                        state   <= ST_DONE;
                        running <= 1'b0;
                     end
                  end
               end
            end
            ST_PAUSE: begin
               if (cmd_stop) begin
                  state <= ST_IDLE;
                  acc   <= '0;
                  total <= '0;
               end else if (cmd_start) begin
                  state   <= ST_COUNT;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_min_t     = disp.min_t;
   assign bus.o_min_o     = disp.min_o;
   assign bus.o_sec_t     = disp.sec_t;
   assign bus.o_sec_o     = disp.sec_o;
   assign bus.o_total_sec = total;
   assign bus.o_tick      = tick;
   assign bus.o_wrap      = wrap;
   assign bus.o_done      = done;
   assign bus.o_running   = running;

endmodule

// File: tb/tb_elapsed_time_counter.sv
// Directed bench for elapsed_time_counter with CLK_HZ = 10.
module tb_elapsed_time_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   elapsed_time_counter_if #(.SPD_W(3)) bus ();

   elapsed_time_counter #(
      .CLK_HZ  (10),
      .SPD_W   (3),
      .MAX_MIN (99)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        down;
      logic [6:0]  pmin;
      logic [5:0]  psec;
      logic        fast;
      logic        slow;
      logic [2:0]  spd;
      int          n;
      logic [31:0] mask;
      logic [12:0] total;
      logic [15:0] digits;
      int          dones;
      logic        running;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   int checks = 0;
   int passed = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [15:0] digits();
      return {bus.o_min_t, bus.o_min_o, bus.o_sec_t, bus.o_sec_o};
   endfunction

   task automatic pulse_start();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.i_stop = 1'b1;
      step();
      bus.i_stop = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] mask;
      int dones, lone, wraps, cnt, first;
      bit hit;

      //             down  pmin    psec   fast  slow  spd   n    mask          total     digits    dn run
      vecs[0] = '{1'b0, 7'd0,   6'd0,  1'b0, 1'b0, 3'd0, 35,  32'h40100400, 13'd3,    16'h0003, 0, 1'b1};
      vecs[1] = '{1'b0, 7'd0,   6'd0,  1'b1, 1'b0, 3'd3, 10,  32'h00000528, 13'd4,    16'h0004, 0, 1'b1};
      vecs[2] = '{1'b0, 7'd0,   6'd0,  1'b0, 1'b1, 3'd1, 40,  32'h00100000, 13'd2,    16'h0002, 0, 1'b1};
      vecs[3] = '{1'b1, 7'd0,   6'd2,  1'b0, 1'b0, 3'd0, 20,  32'h00100400, 13'd0,    16'h0000, 1, 1'b0};
      vecs[4] = '{1'b1, 7'd1,   6'd5,  1'b1, 1'b0, 3'd7, 10,  32'h000007BC, 13'd57,   16'h0057, 0, 1'b1};
      vecs[5] = '{1'b1, 7'd127, 6'd63, 1'b0, 1'b0, 3'd0, 10,  32'h00000400, 13'd5998, 16'h9958, 0, 1'b1};
      vecs[6] = '{1'b0, 7'd0,   6'd0,  1'b1, 1'b0, 3'd7, 100, 32'h7BDEF7BC, 13'd80,   16'h0120, 0, 1'b1};

      bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0; bus.i_down = 1'b0;
      bus.i_preset_min = '0; bus.i_preset_sec = '0;
      bus.i_fast = 1'b0; bus.i_slow = 1'b0; bus.i_speed = '0;

      // Reset state
      step(); step();
      chk("rst_digits", 32'(digits()), 32'h0);
      chk("rst_total", 32'(bus.o_total_sec), 32'd0);
      chk("rst_running", 32'(bus.o_running), 32'd0);
      chk("rst_tick", 32'(bus.o_tick), 32'd0);
      rst = 1'b0;
      step();

      // Table-driven runs: stop, configure, start, count N cycles
      for (int i = 0; i < NV; i++) begin
         pulse_stop();
         chk($sformatf("v%0d_stop_total", i), 32'(bus.o_total_sec), 32'd0);
         chk($sformatf("v%0d_stop_running", i), 32'(bus.o_running), 32'd0);
         bus.i_down = vecs[i].down;
         bus.i_preset_min = vecs[i].pmin;
         bus.i_preset_sec = vecs[i].psec;
         bus.i_fast = vecs[i].fast;
         bus.i_slow = vecs[i].slow;
         bus.i_speed = vecs[i].spd;
         pulse_start();
         mask = '0; dones = 0; lone = 0; wraps = 0;
         for (int c = 1; c <= vecs[i].n; c++) begin
            step();
            if (bus.o_tick && c < 32) mask[c] = 1'b1;
            if (bus.o_done) begin
               if (bus.o_tick) dones++;
               else lone++;
            end
            if (bus.o_wrap) wraps++;
         end
         chk($sformatf("v%0d_tick_mask", i), mask, vecs[i].mask);
         chk($sformatf("v%0d_total", i), 32'(bus.o_total_sec), 32'(vecs[i].total));
         chk($sformatf("v%0d_digits", i), 32'(digits()), 32'(vecs[i].digits));
         chk($sformatf("v%0d_done_with_tick", i), 32'(dones), 32'(vecs[i].dones));
         chk($sformatf("v%0d_done_alone", i), 32'(lone), 32'd0);
         chk($sformatf("v%0d_wraps", i), 32'(wraps), 32'd0);
         chk($sformatf("v%0d_running", i), 32'(bus.o_running), 32'(vecs[i].running));
      end

      // Pause/resume at slow 2x: 15 active cycles, 7 paused, tick at cycle 27
      pulse_stop();
      bus.i_down = 1'b0; bus.i_fast = 1'b0; bus.i_slow = 1'b1; bus.i_speed = 3'd1;
      pulse_start();
      cnt = 0;
      for (int c = 1; c <= 15; c++) begin
         if (c == 5) bus.i_start = 1'b1;
         step();
         bus.i_start = 1'b0;
         if (bus.o_tick) cnt++;
      end
      bus.i_pause = 1'b1;
      step();
      bus.i_pause = 1'b0;
      chk("pause_running", 32'(bus.o_running), 32'd0);
      for (int c = 17; c <= 21; c++) begin
         if (c == 18) bus.i_pause = 1'b1;
         step();
         bus.i_pause = 1'b0;
         if (bus.o_tick) cnt++;
      end
      chk("pause_no_ticks", 32'(cnt), 32'd0);
      chk("pause_still_paused", 32'(bus.o_running), 32'd0);
      pulse_start();
      chk("resume_running", 32'(bus.o_running), 32'd1);
      first = 0;
      for (int c = 23; c <= 30; c++) begin
         step();
         if (bus.o_tick && first == 0) first = c;
      end
      chk("resume_first_tick", 32'(first), 32'd27);
      chk("resume_total", 32'(bus.o_total_sec), 32'd1);

      // Down start with preset 00:00 goes straight to DONE
      pulse_stop();
      bus.i_slow = 1'b0; bus.i_speed = '0; bus.i_down = 1'b1;
      bus.i_preset_min = 7'd0; bus.i_preset_sec = 6'd0;
      pulse_start();
      chk("zero_done", 32'(bus.o_done), 32'd1);
      chk("zero_tick", 32'(bus.o_tick), 32'd0);
      chk("zero_running", 32'(bus.o_running), 32'd0);
      chk("zero_digits", 32'(digits()), 32'h0);
      step();
      chk("zero_done_single", 32'(bus.o_done), 32'd0);

      // Up count at 8x to 99:59, then the wrap tick
      pulse_stop();
      bus.i_down = 1'b0; bus.i_fast = 1'b1; bus.i_speed = 3'd7;
      pulse_start();
      cnt = 0; wraps = 0;
      while (bus.o_total_sec != 13'd5999 && cnt < 8000) begin
         step();
         cnt++;
         if (bus.o_wrap) wraps++;
      end
      chk("wrap_reached_max", 32'(bus.o_total_sec), 32'd5999);
      chk("wrap_max_digits", 32'(digits()), 32'h9959);
      chk("wrap_none_early", 32'(wraps), 32'd0);
      hit = 1'b0;
      for (int c = 0; c < 4 && !hit; c++) begin
         step();
         hit = bus.o_tick;
      end
      chk("wrap_tick_seen", 32'(hit), 32'd1);
      chk("wrap_pulse", 32'(bus.o_wrap), 32'd1);
      chk("wrap_digits", 32'(digits()), 32'h0);
      chk("wrap_total", 32'(bus.o_total_sec), 32'd0);
      chk("wrap_running", 32'(bus.o_running), 32'd1);
      bus.i_stop = 1'b1; bus.i_pause = 1'b1;
      step();
      bus.i_stop = 1'b0; bus.i_pause = 1'b0;
      chk("stop_over_pause_running", 32'(bus.o_running), 32'd0);
      chk("stop_over_pause_digits", 32'(digits()), 32'h0);

      // Reset mid-count at 12:34 with a simultaneous start
      pulse_start();
      cnt = 0;
      while (bus.o_total_sec != 13'd754 && cnt < 1200) begin
         step();
         cnt++;
      end
      chk("rst_mid_reached", 32'(digits()), 32'h1234);
      rst = 1'b1; bus.i_start = 1'b1;
      step();
      rst = 1'b0; bus.i_start = 1'b0;
      chk("rst_mid_running", 32'(bus.o_running), 32'd0);
      chk("rst_mid_digits", 32'(digits()), 32'h0);
      chk("rst_mid_total", 32'(bus.o_total_sec), 32'd0);
      chk("rst_mid_tick", 32'(bus.o_tick), 32'd0);
      step();
      chk("rst_mid_stays_idle", 32'(bus.o_running), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/elapsed_time_counter.md
ELAPSED_TIME_COUNTER -- requirements
Module: elapsed_time_counter

Interface
REQ-001 Parameter CLK_HZ, default 12000000: clock cycles per real second at speed 1x.
REQ-002 Parameter SPD_W, default 3: width of speed code; scale factor = i_speed+1.
REQ-003 Parameter MAX_MIN, default 99: highest minute value, at most 99.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 i_start, i_pause, i_stop  in  1 each  single-cycle command pulses.
REQ-007 i_down  in  1  sampled at start from IDLE/DONE: 1 = count down from preset, 0 = count up from 00:00.
REQ-008 i_preset_min  in  7 / i_preset_sec  in  6  binary countdown preset, sampled at start.
REQ-009 i_fast, i_slow  in  1 / i_speed  in  SPD_W  playback rate select; i_fast has priority over i_slow.
REQ-010 o_min_t, o_min_o, o_sec_t, o_sec_o  out  4 each  BCD digits of mm:ss.
REQ-011 o_total_sec  out  13  binary elapsed/remaining seconds, equals 60*min+sec.
REQ-012 o_tick  out  1  one-cycle pulse each displayed-second advance.
REQ-013 o_wrap  out  1  one-cycle pulse on up-count wrap; o_done  out  1  one-cycle pulse on reaching 00:00 down.
REQ-014 o_running  out  1  high only in COUNT.

Function
REQ-015 States: IDLE, COUNT, PAUSE, DONE; command priority stop > pause > start.
REQ-016 IDLE/DONE + start: load time (00:00 if up; clamped preset if down), clear accumulator, enter COUNT next cycle.
REQ-017 Preset clamp: sec >59 -> 59, min >MAX_MIN -> MAX_MIN.
REQ-018 COUNT + stop -> IDLE, time 00:00, accumulator 0; PAUSE + stop identical.
REQ-019 COUNT + pause -> PAUSE, time and accumulator frozen; PAUSE + start -> COUNT, resume from frozen accumulator; start in COUNT, pause in PAUSE/IDLE ignored.
REQ-020 Rate via phase accumulator, no divider: fast -> step=i_speed+1, threshold=CLK_HZ; slow -> step=1, threshold=CLK_HZ*(i_speed+1); else step=1, threshold=CLK_HZ.
REQ-021 Each COUNT cycle: acc+step >= threshold -> acc <= acc+step-threshold and one second advance; else acc <= acc+step.
REQ-022 At most one second advance per cycle; rate/speed changes mid-count take effect on the next cycle with accumulator retained.
REQ-023 Accumulator width = clog2(CLK_HZ*2^SPD_W)+1 bits; no overflow for any legal input.
REQ-024 Up: ss 59 -> 00 with mm+1; at MAX_MIN:59 -> 00:00, o_wrap pulses with o_tick, counting continues.
REQ-025 Down: ss 00 -> 59 with mm-1; reaching 00:00 -> DONE same edge, o_done pulses with final o_tick.
REQ-026 Down start with clamped preset 00:00 -> DONE next cycle, o_done pulse, no o_tick.
REQ-027 DONE holds 00:00 until start or stop; stop -> IDLE.
REQ-028 All outputs registered; digits and o_total_sec update on the same edge as o_tick.

Reset
REQ-029 rst high at any clock edge, including mid-count: state IDLE, accumulator 0, all digits 0, o_total_sec 0, all pulses and o_running 0; commands in the reset cycle ignored.

Structure
REQ-030 Package time_pkg holds state enum, default CLK_HZ, BCD digit typedef, MAX_MIN limit.
REQ-031 Sub-module time_bcd_counter: mm:ss BCD up/down counter with load, enable, wrap and zero flags; FSM and accumulator stay in the top.

Verification (CLK_HZ=10 in simulation)
REQ-032 Up start, 1x, 35 cycles -> o_tick at cycles 10, 20, 30; display 00:03; o_total_sec 3.
REQ-033 i_fast, i_speed=3 -> o_tick every 10/4 cycles average: 4 ticks in 10 cycles, spacing 2,3,2,3.
REQ-034 i_slow, i_speed=1, pause at cycle 15 for 7 cycles, resume -> first tick at active cycle 20 (cycle 27).
REQ-035 Down preset 0:02 -> ticks at 10, 20; display 00:00; o_done with second tick; state DONE; preset 0:00 -> o_done next cycle.
REQ-036 Up preload via force to 99:59, one tick -> 00:00, o_wrap and o_tick same cycle.
REQ-037 rst during COUNT at 12:34, simultaneous start -> next cycle IDLE, 00:00, o_running 0.
